// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: CPU/DMA arbiter for the shared memory bus, with a parked CPU and bounded, lockable DMA bursts.
module mem_bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic        CPU_req,
  input  logic [15:0] CPU_MAB,
  input  logic [15:0] CPU_MDBwrite,
  input  logic        CPU_MW,
  input  logic        CPU_BW,
  output logic        CPU_gnt,
  output logic [15:0] CPU_MDBread,
  input  logic        DMA_req,
  input  logic        DMA_lock,
  input  logic [15:0] DMA_MAB,
  input  logic [15:0] DMA_MDBwrite,
  input  logic        DMA_MW,
  input  logic        DMA_BW,
  output logic        DMA_gnt,
  output logic [15:0] DMA_MDBread,
  output logic [15:0] MAB,
  output logic [15:0] MDBwrite,
  output logic        MW,
  output logic        BW,
  input  logic [15:0] MDBread,
  output logic [7:0]  burst_cnt
);
  typedef enum logic {CPU_OWN, DMA_OWN} state_t;
  state_t     state, state_nxt;
  logic [7:0] cnt_nxt;
  logic       dma_sel;
  logic       limit_hit;
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state     <= CPU_OWN;
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
    end
  end
  assign limit_hit = ~DMA_lock & CPU_req & (burst_cnt >= 8'(MAX_BURST));
  always_comb begin
    state_nxt = state;
    cnt_nxt   = 8'd0;
    if (state == CPU_OWN) begin
      state_nxt = DMA_req ? DMA_OWN : CPU_OWN;
      cnt_nxt   = DMA_req ? 8'd1 : 8'd0;
    end else begin
      state_nxt = (~DMA_req | limit_hit) ? CPU_OWN : DMA_OWN;
      cnt_nxt   = (~DMA_req | limit_hit) ? 8'd0 : burst_cnt + {7'd0, burst_cnt != 8'hff};
    end
  end
  // Reset forces the mux back to the CPU side so the memory sees CPU inputs with MW low.
  assign dma_sel     = (state == DMA_OWN) & ~RST;
  assign CPU_gnt     = ~dma_sel & ~RST;
  assign DMA_gnt     = dma_sel;
  assign MAB         = dma_sel ? DMA_MAB : CPU_MAB;
  assign MDBwrite    = dma_sel ? DMA_MDBwrite : CPU_MDBwrite;
  assign BW          = dma_sel ? DMA_BW : CPU_BW;
  assign MW          = dma_sel ? (DMA_MW & DMA_req) : (CPU_MW & CPU_req & ~RST);
  assign CPU_MDBread = dma_sel ? 16'h0000 : MDBread;
  assign DMA_MDBread = dma_sel ? MDBread : 16'h0000;
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single system memory bus (MAB, MDBwrite, MW, BW, MDBread) between the CPU and the DMA controller ahead of the block-memory interface. The CPU is the parked default owner and has zero-latency access when the DMA is idle. The DMA is granted the bus in bounded bursts, with an optional lock for atomic sequences. Grant state is registered on MCLK rising edges; the bus mux is combinational from that state, so the falling-edge-clocked block memories see stable MAB, MW and BW.

## Interface
- MAX_BURST, 4: maximum consecutive DMA-owned cycles while the CPU is requesting (1..255).
- MCLK  in  1  system clock; all state updates occur on the rising edge.
- RST  in  1  synchronous, active-high reset.
- CPU_req  in  1  CPU access valid this cycle.
- CPU_MAB, CPU_MDBwrite  in  16  CPU address and write data.
- CPU_MW, CPU_BW  in  1  CPU write strobe and byte access.
- CPU_gnt  out  1  CPU owns the bus this cycle; when low, the CPU must stall and hold its request.
- CPU_MDBread  out  16  read data to the CPU.
- DMA_req  in  1  DMA access valid this cycle.
- DMA_lock  in  1  DMA requests that the burst limit be ignored (atomic sequence).
- DMA_MAB, DMA_MDBwrite  in  16  DMA address and write data.
- DMA_MW, DMA_BW  in  1  DMA write strobe and byte access.
- DMA_gnt  out  1  DMA owns the bus this cycle.
- DMA_MDBread  out  16  read data to the DMA.
- MAB, MDBwrite  out  16  address and write data to the memory interface.
- MW, BW  out  1  write strobe and byte access to the memory interface.
- MDBread  in  16  read data from the memory interface.
- burst_cnt  out  8  number of DMA-owned cycles in the current burst (debug).

## Operation
- Two states: CPU_OWN (reset and park state) and DMA_OWN. CPU_gnt = (state==CPU_OWN) & ~RST. DMA_gnt = (state==DMA_OWN) & ~RST.
- Bus mux: the owner's MAB, MDBwrite and BW are driven to the memory interface. MW = owner_MW & owner_req & ~RST, so no write is issued during reset or by an idle owner.
- Read return: MDBread is routed to the owner's MDBread port. The non-owner's MDBread port reads 16'h0000.
- CPU_OWN -> DMA_OWN at an edge where DMA_req=1; burst_cnt is loaded with 1. Otherwise the state stays CPU_OWN and burst_cnt holds 0.
- DMA_OWN -> CPU_OWN at an edge where DMA_req=0, or where DMA_lock=0 & CPU_req=1 & burst_cnt>=MAX_BURST. burst_cnt clears to 0 on this transition.
- Otherwise DMA_OWN is held and burst_cnt increments, saturating at 255.
- Fairness: after a limit-forced return, the CPU owns the bus for at least one full cycle before the DMA can be regranted.
- If CPU_req=0, the DMA may hold the bus indefinitely; burst_cnt saturates.
- With DMA_lock=1, the DMA keeps the bus while DMA_req=1 regardless of the limit. When lock drops with burst_cnt>=MAX_BURST and CPU_req=1, the bus returns at the next edge.

## Timing
- Reset values: state CPU_OWN, burst_cnt 0, CPU_gnt 0 and DMA_gnt 0 while RST=1; CPU_gnt 1 in the first cycle after RST deasserts. MW=0 while RST=1. MAB, MDBwrite and BW follow the CPU inputs.
- CPU latency while parked: 0 cycles; the access completes in the same cycle.
- DMA latency: DMA_req high in cycle n gives DMA_gnt in cycle n+1. The DMA holds its request and data until it sees DMA_gnt.
- Handover costs no idle cycle: the last CPU cycle is n and the first DMA cycle is n+1, or the reverse.
- Grants change only at rising edges. Block memories sample on falling edges, so the mux is settled by mid-cycle.
- Simultaneous requests in CPU_OWN: the CPU completes this cycle and the DMA gets the bus next cycle.
- DMA_req dropping in a DMA_OWN cycle: MW is gated low in that cycle and the CPU owns the bus next cycle.
- Reset mid-burst: the in-flight DMA write is suppressed, and the block is in CPU_OWN with burst_cnt=0 at the next edge.

## Test plan
- Reset, then CPU-only writes: CPU writes 16'hBEEF to 16'h2000 with DMA_req=0 -> CPU_gnt=1 every cycle, MW=1, MAB=16'h2000. A readback on CPU_MDBread gives 16'hBEEF in the same cycle.
- Single DMA access: DMA_req for one access to 16'h2004 with CPU idle -> DMA_gnt in the next cycle, write lands, CPU_gnt back 1 cycle later, burst_cnt returns to 0.
- Burst limit, MAX_BURST=4: both requesting continuously -> pattern 4 DMA cycles, 1 CPU cycle, repeated. burst_cnt reads 1,2,3,4 in the DMA cycles.
- Lock: DMA_lock=1 for 10 cycles with CPU_req=1 -> DMA_gnt held for 10 cycles. Lock drops with burst_cnt=10 -> CPU_gnt at the next edge.
- Byte routing: the DMA reads a byte while the CPU is stalled -> CPU_MDBread=16'h0000, DMA_MDBread equals MDBread, and BW follows DMA_BW.
- Reset mid-burst: RST=1 in the 2nd DMA cycle with DMA_MW=1 -> MW=0 in that cycle, and CPU_OWN with burst_cnt=0 after the edge.
